// File: rtl/ahb_slave_mem_if.sv
// Bus-side signal bundle for one AHB slave port: the interconnect drives the
// master modport, ahb_slave_mem terminates the slave modport.
interface ahb_slave_mem_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB slave word memory: pipelined address/data phases, programmable wait
// states, two-cycle ERROR response for misaligned or out-of-range transfers.
module ahb_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic           hclk,
    input  logic           hreset,
    ahb_slave_mem_if.slave bus
);
    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] mem_d [MEM_WORDS];

    logic          can_accept;
    logic          accept;
    logic          addr_err;
    logic [32:0]   req_diff;
    logic [31:0]   dat_off;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   merged;
    logic          unused_bits;

    // 33-bit difference: bit 32 set means haddr is below BASE_ADDR, which the
    // single >= compare against MEM_BYTES also rejects.
    assign req_diff = {1'b0, bus.haddr} - {1'b0, BASE_ADDR};

    always_comb begin
        addr_err = 1'b0;
        if (bus.hsize > 3'd2)                               addr_err = 1'b1;
        if (bus.hsize == 3'd1 && bus.haddr[0])              addr_err = 1'b1;
        if (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'b00)   addr_err = 1'b1;
        if (req_diff >= MEM_BYTES)                          addr_err = 1'b1;
    end

    assign can_accept = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
    assign accept     = can_accept && bus.hsel && bus.hready && bus.htrans[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        unique case (state_q)
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_DATA;
                else             cnt_d   = cnt_q - 4'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    addr_d  = bus.haddr;
                    write_d = bus.hwrite;
                    size_d  = bus.hsize;
                    if (addr_err) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
    end

    assign dat_off = addr_q - BASE_ADDR;
    assign idx     = dat_off[AW+1:2];

    always_comb begin
        unique case (size_q)
            3'd0:    be = 4'b0001 << addr_q[1:0];
            3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        merged = mem_q[idx];
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) merged[i*8 +: 8] = bus.hwdata[i*8 +: 8];
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (state_q == S_DATA && write_q) mem_d[idx] = merged;
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            mem_q   <= mem_d;
        end
    end

    assign bus.hreadyout = !((state_q == S_WAIT) || (state_q == S_ERR1));
    assign bus.hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign bus.hrdata    = (state_q == S_DATA && !write_q) ? mem_q[idx] : '0;

    assign unused_bits = ^{bus.hburst, dat_off[31:AW+2], dat_off[1:0]};
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench: three slave configurations on a shared clock/reset,
// directed scenarios plus randomized transfers checked against a byte-array model.
module tb_ahb_slave_mem;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  cur;
    logic        t_sel, t_write, hold_low;
    logic [31:0] t_addr, t_wdata;
    logic [1:0]  t_trans;
    logic [2:0]  t_size, t_burst;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;
    int unsigned fail_cnt = 0;

    ahb_slave_mem_if ifs [3] ();

    ahb_slave_mem #(.BASE_ADDR(32'h0000_0000), .MEM_WORDS(256), .WAIT_STATES(0))
        dut0 (.hclk(clk), .hreset(rst), .bus(ifs[0].slave));
    ahb_slave_mem #(.BASE_ADDR(32'h0000_0000), .MEM_WORDS(256), .WAIT_STATES(2))
        dut1 (.hclk(clk), .hreset(rst), .bus(ifs[1].slave));
    ahb_slave_mem #(.BASE_ADDR(32'h0000_0400), .MEM_WORDS(64), .WAIT_STATES(3))
        dut2 (.hclk(clk), .hreset(rst), .bus(ifs[2].slave));

    logic        rdy_v  [3];
    logic        resp_v [3];
    logic [31:0] rd_v   [3];

    for (genvar g = 0; g < 3; g++) begin : g_bus
        assign ifs[g].hsel   = t_sel && (cur == 2'(g));
        assign ifs[g].haddr  = t_addr;
        assign ifs[g].htrans = t_trans;
        assign ifs[g].hwrite = t_write;
        assign ifs[g].hsize  = t_size;
        assign ifs[g].hburst = t_burst;
        assign ifs[g].hwdata = t_wdata;
        assign ifs[g].hready = ifs[g].hreadyout && !(hold_low && (cur == 2'(g)));
        assign rdy_v[g]  = ifs[g].hreadyout;
        assign resp_v[g] = ifs[g].hresp;
        assign rd_v[g]   = ifs[g].hrdata;
    end

    logic        o_ready, o_resp;
    logic [31:0] o_rdata;
    assign o_ready = rdy_v[cur];
    assign o_resp  = resp_v[cur];
    assign o_rdata = rd_v[cur];

    // Reference model: byte-addressed storage per instance, offsets from BASE.
    logic [31:0] base_a  [3] = '{32'h0, 32'h0, 32'h400};
    int unsigned words_a [3] = '{256, 256, 64};
    int unsigned ws_a    [3] = '{0, 2, 3};
    logic [7:0]  bmem [3][1024];

    task automatic clear_model();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 1024; i++) bmem[k][i] = 8'h00;
    endtask

    function automatic bit model_err(input logic [1:0] k, input logic [31:0] a, input logic [2:0] sz);
        longint off;
        off = longint'(a) - longint'(base_a[k]);
        if (sz > 3'd2) return 1'b1;
        if ((a % (32'd1 << sz)) != 0) return 1'b1;
        if (off < 0 || off >= longint'(words_a[k]) * 4) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_write(input logic [1:0] k, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        longint off;
        int unsigned lane;
        off = longint'(a) - longint'(base_a[k]);
        for (int b = 0; b < (1 << sz); b++) begin
            lane = (a + 32'(b)) % 4;
            bmem[k][int'(off) + b] = wd[lane*8 +: 8];
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] k, input logic [31:0] a);
        int w;
        w = (int'(longint'(a) - longint'(base_a[k])) / 4) * 4;
        return {bmem[k][w+3], bmem[k][w+2], bmem[k][w+1], bmem[k][w]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        t_sel = 1'b0; t_trans = 2'b00; t_write = 1'b0; t_addr = '0; t_size = '0;
    endtask

    task automatic addr_phase(input logic w, input logic [31:0] a, input logic [2:0] sz, input logic [1:0] tr);
        t_sel = 1'b1; t_trans = tr; t_write = w; t_addr = a; t_size = sz;
        t_burst = 3'($urandom_range(0, 7));
    endtask

    // Called on a negedge inside a data phase; returns at the completing cycle.
    task automatic finish_phase(output int low, output logic lresp, output logic fresp, output logic [31:0] rd);
        low = 0; lresp = 1'b0;
        while (o_ready !== 1'b1 && low < 40) begin
            lresp = lresp | o_resp;
            low++;
            @(negedge clk);
        end
        fresp = o_resp;
        rd    = o_rdata;
    endtask

    task automatic do_xfer(input string tag, input logic w, input logic [31:0] a,
                           input logic [2:0] sz, input logic [31:0] wd, output logic [31:0] rd);
        bit err; int low; logic lr, fr;
        err = model_err(cur, a, sz);
        @(negedge clk); addr_phase(w, a, sz, 2'b10);
        @(negedge clk); bus_idle(); t_wdata = wd;
        finish_phase(low, lr, fr, rd);
        check({tag, "_waits"}, 32'(low), err ? 32'd1 : ws_a[cur]);
        check({tag, "_lowresp"}, 32'(lr), 32'(err));
        check({tag, "_resp"}, 32'(fr), 32'(err));
        check({tag, "_rdata"}, rd, (!w && !err) ? model_read(cur, a) : 32'h0);
        if (w && !err) model_write(cur, a, sz, wd);
    endtask

    task automatic non_xfer(input string tag, input logic sel, input logic [1:0] tr, input logic hl);
        @(negedge clk);
        t_sel = sel; t_trans = tr; t_write = 1'b1; t_addr = 32'h40; t_size = 3'd2; hold_low = hl;
        @(negedge clk); bus_idle(); hold_low = 1'b0; t_wdata = 32'h5A5A_5A5A;
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
        check({tag, "_resp"}, 32'(o_resp), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a, wd;
        logic [2:0]  sz;
        logic        w;
        int          low;
        logic        lr, fr;
        int unsigned r;

        rst = 1'b1; cur = 2'd0; hold_low = 1'b0; t_burst = '0; t_wdata = '0;
        bus_idle();
        clear_model();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            cur = 2'(k);
            #1;
            check("reset_ready", 32'(o_ready), 32'd1);
            check("reset_resp", 32'(o_resp), 32'd0);
            check("reset_rdata", o_rdata, 32'h0);
        end
        @(negedge clk); rst = 1'b0;

        // Back-to-back write then read of the same word, zero wait states.
        cur = 2'd0;
        @(negedge clk); addr_phase(1'b1, 32'h10, 3'd2, 2'b10);
        @(negedge clk); t_wdata = 32'hDEAD_BEEF; addr_phase(1'b0, 32'h10, 3'd2, 2'b10);
        check("b2b_wr_ready", 32'(o_ready), 32'd1);
        @(negedge clk); bus_idle();
        check("b2b_rd_ready", 32'(o_ready), 32'd1);
        check("b2b_rd_data", o_rdata, 32'hDEAD_BEEF);
        model_write(2'd0, 32'h10, 3'd2, 32'hDEAD_BEEF);

        // Byte and halfword lanes.
        do_xfer("w20", 1'b1, 32'h20, 3'd2, 32'h1122_3344, rd);
        do_xfer("b22", 1'b1, 32'h22, 3'd0, 32'h00AA_0000, rd);
        do_xfer("r20a", 1'b0, 32'h20, 3'd2, 32'h0, rd);
        check("lane_byte", rd, 32'h11AA_3344);
        do_xfer("h20", 1'b1, 32'h20, 3'd1, 32'h0000_BBCC, rd);
        do_xfer("r20b", 1'b0, 32'h20, 3'd2, 32'h0, rd);
        check("lane_half", rd, 32'h11AA_BBCC);

        // Errors, then word 0 must be unaffected.
        do_xfer("w0", 1'b1, 32'h0, 3'd2, 32'h0BAD_F00D, rd);
        do_xfer("err_rd402", 1'b0, 32'h402, 3'd2, 32'h0, rd);
        do_xfer("err_wr400", 1'b1, 32'h400, 3'd2, 32'h1234_5678, rd);
        do_xfer("err_half21", 1'b1, 32'h21, 3'd1, 32'hFFFF_FFFF, rd);
        do_xfer("err_size3", 1'b0, 32'h0, 3'd3, 32'h0, rd);
        do_xfer("after_err", 1'b0, 32'h0, 3'd2, 32'h0, rd);
        check("after_err_word0", rd, 32'h0BAD_F00D);

        // Read held through ERR1 is taken in ERR2 and completes next cycle.
        @(negedge clk); addr_phase(1'b1, 32'h400, 3'd2, 2'b10);
        @(negedge clk); addr_phase(1'b0, 32'h20, 3'd2, 2'b10);
        check("err1_ready", 32'(o_ready), 32'd0);
        check("err1_resp", 32'(o_resp), 32'd1);
        @(negedge clk);
        check("err2_ready", 32'(o_ready), 32'd1);
        check("err2_resp", 32'(o_resp), 32'd1);
        @(negedge clk); bus_idle();
        check("post_err2_ready", 32'(o_ready), 32'd1);
        check("post_err2_resp", 32'(o_resp), 32'd0);
        check("post_err2_rdata", o_rdata, model_read(2'd0, 32'h20));

        // Non-transfers leave the word at 0x40 untouched.
        do_xfer("w40", 1'b1, 32'h40, 3'd2, 32'hCAFE_F00D, rd);
        non_xfer("nt_busy", 1'b1, 2'b01, 1'b0);
        non_xfer("nt_idle", 1'b1, 2'b00, 1'b0);
        non_xfer("nt_nosel", 1'b0, 2'b10, 1'b0);
        non_xfer("nt_notready", 1'b1, 2'b10, 1'b1);
        do_xfer("r40", 1'b0, 32'h40, 3'd2, 32'h0, rd);
        check("nt_mem_kept", rd, 32'hCAFE_F00D);

        // Wait states: SEQ beat held during WAIT is taken only on the ready edge.
        cur = 2'd1;
        do_xfer("ws_w0", 1'b1, 32'h0, 3'd2, $urandom, rd);
        do_xfer("ws_w4", 1'b1, 32'h4, 3'd2, $urandom, rd);
        do_xfer("ws_r0", 1'b0, 32'h0, 3'd2, 32'h0, rd);
        @(negedge clk); addr_phase(1'b0, 32'h0, 3'd2, 2'b10);
        @(negedge clk); addr_phase(1'b0, 32'h4, 3'd2, 2'b11);
        finish_phase(low, lr, fr, rd);
        check("seq_b1_waits", 32'(low), 32'd2);
        check("seq_b1_rdata", rd, model_read(2'd1, 32'h0));
        @(negedge clk); bus_idle();
        finish_phase(low, lr, fr, rd);
        check("seq_b2_waits", 32'(low), 32'd2);
        check("seq_b2_resp", 32'(fr), 32'd0);
        check("seq_b2_rdata", rd, model_read(2'd1, 32'h4));

        // Range boundaries with a non-zero base.
        cur = 2'd2;
        do_xfer("below_base", 1'b0, 32'h3FC, 3'd2, 32'h0, rd);
        do_xfer("past_end", 1'b1, 32'h500, 3'd2, 32'h1, rd);
        do_xfer("last_wr", 1'b1, 32'h4FC, 3'd2, 32'h7777_8888, rd);
        do_xfer("last_rd", 1'b0, 32'h4FC, 3'd2, 32'h0, rd);
        check("last_word", rd, 32'h7777_8888);

        // Randomized transfers on every configuration.
        for (int k = 0; k < 3; k++) begin
            cur = 2'(k);
            repeat (40) begin
                r  = $urandom_range(0, 9);
                sz = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                if (r < 7)      a = base_a[k] + $urandom_range(0, words_a[k]*4 - 1);
                else if (r < 9) a = base_a[k] + words_a[k]*4 - 4 + $urandom_range(0, 11);
                else            a = base_a[k] - 32'($urandom_range(1, 8));
                if ($urandom_range(0, 4) != 0 && sz < 3'd3) a = a & ~((32'd1 << sz) - 32'd1);
                w  = 1'($urandom_range(0, 1));
                wd = $urandom;
                do_xfer("rand", w, a, sz, wd, rd);
            end
        end

        // Asynchronous reset in the middle of a wait sequence.
        cur = 2'd2;
        do_xfer("pre_rst_w", 1'b1, 32'h430, 3'd2, $urandom | 32'h1, rd);
        @(negedge clk); addr_phase(1'b0, 32'h430, 3'd2, 2'b10);
        @(negedge clk); bus_idle();
        check("rst_pre_wait", 32'(o_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_ready", 32'(o_ready), 32'd1);
        check("rst_mid_resp", 32'(o_resp), 32'd0);
        check("rst_mid_rdata", o_rdata, 32'h0);
        @(negedge clk); rst = 1'b0;
        clear_model();
        do_xfer("rst_rd430", 1'b0, 32'h430, 3'd2, 32'h0, rd);
        check("rst_mem_cleared", rd, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
